weight_loader: RTL and testbench
================================

WEIGHT_LOADER -- requirements
Module: weight_loader

Interface
REQ-001 Parameter ROWS, default 3, number of weight-matrix rows.
REQ-002 Parameter COLS, default 4, number of weight-matrix columns.
REQ-003 clk  input  1  single clock; all logic on posedge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 WEIGHT_AXIS_TDATA  input  32  weight word, IEEE-754 single, row-major order.
REQ-006 WEIGHT_AXIS_TLAST  input  1  marks final beat of a matrix frame.
REQ-007 WEIGHT_AXIS_TVALID  input  1  upstream beat valid.
REQ-008 WEIGHT_AXIS_TREADY  output  1  loader accepts beat.
REQ-009 weights  output  32 x [0:ROWS-1][0:COLS-1]  active matrix, drives the weights port of the dot engine.
REQ-010 weights_valid  output  1  active matrix holds at least one committed frame.
REQ-011 hold  input  1  high while the dot engine is computing; blocks commit.
REQ-012 load_error  output  1  last frame was malformed (short or long).

Function
REQ-013 The block SHALL keep a shadow matrix (ROWS x COLS x 32) separate from the active weights registers; stream beats write only the shadow.
REQ-014 A beat SHALL transfer on any posedge where TVALID and TREADY are both high; data is stored without modification.
REQ-015 The block SHALL track row index r (0..ROWS-1), column index c (0..COLS-1), and beat index k = r*COLS + c.
REQ-016 Each accepted beat in ST_LOAD SHALL write shadow[r][c] and advance c; when c = COLS-1, c wraps to 0 and r increments.
REQ-017 States SHALL be ST_LOAD, ST_DRAIN and ST_COMMIT.
REQ-018 ST_LOAD: TREADY = 1.
  - Accepted beat with k = ROWS*COLS-1 and TLAST = 1 -> ST_COMMIT.
  - Accepted beat with k = ROWS*COLS-1 and TLAST = 0 -> ST_DRAIN; load_error <= 1.
  - Accepted beat with TLAST = 1 and k < ROWS*COLS-1 (short frame) -> stay in ST_LOAD; r, c <= 0; load_error <= 1; active weights unchanged.
REQ-019 ST_DRAIN: TREADY = 1; beats are discarded with no shadow write. The TLAST beat -> ST_LOAD with r, c <= 0.
REQ-020 ST_COMMIT: TREADY = 0.
  - hold = 0: at the next posedge, all of weights <= shadow in one cycle; weights_valid <= 1; load_error <= 0; r, c <= 0; -> ST_LOAD.
  - hold = 1: remain in ST_COMMIT and do not change weights.
REQ-021 Latency: if the last beat is accepted at edge N and hold is low, weights SHALL update at edge N+1. Each cycle hold stays high delays the commit by one edge.
REQ-022 weights SHALL change only at a commit edge and SHALL never show a partially loaded frame.
REQ-023 A malformed frame SHALL leave weights and weights_valid unchanged.
REQ-024 load_error SHALL be sticky until the next successful commit.
REQ-025 TREADY SHALL be a registered function of state only, never combinationally dependent on TVALID.
REQ-026 The block SHALL sustain one beat per cycle in ST_LOAD, so a frame takes ROWS*COLS cycles plus one commit cycle.
REQ-027 A short-frame TLAST on the same beat that would otherwise end a full frame cannot occur; only k = ROWS*COLS-1 is a full-frame end.

Reset
REQ-028 While rst is high at a posedge, the block SHALL set:
  - state = ST_LOAD; r = c = 0;
  - weights and shadow all 32'h0;
  - weights_valid = 0; load_error = 0;
  - TREADY = 0 in the cycle following that edge.
REQ-029 Reset during a partial frame or in ST_COMMIT SHALL discard the shadow contents and pending commit. The first post-reset beat is treated as k = 0.

Verification (ROWS=3, COLS=4, 12 beats)
REQ-030 Full frame: 12 beats with data 32'h3F800000 + k, TLAST on k=11, hold=0.
  - Expected: weights[1][2] = 32'h3F800006 at edge N+1; weights_valid = 1; load_error = 0.
REQ-031 Hold: same frame, hold = 1 for 5 cycles after the last beat.
  - Expected: TREADY = 0 and weights unchanged for 5 cycles; commit on the edge after hold falls.
REQ-032 Short frame: 7 beats, TLAST on beat 7, then a valid 12-beat frame.
  - Expected: load_error = 1 after beat 7; weights unchanged.
  - Second frame commits correctly and load_error returns to 0.
REQ-033 Long frame: 15 beats, TLAST on beat 15.
  - Expected: ST_DRAIN after beat 12; load_error = 1; beats 13-15 accepted and discarded.
  - No commit; the next frame starts at k = 0.
REQ-034 Backpressure and bubbles: TVALID toggling 1,0,1,0 across a full frame.
  - Expected: exactly 12 writes in order; result matches REQ-030.
REQ-035 Mid-frame reset: rst asserted after 5 beats, then a full frame of 32'h40000000.
  - Expected: weights all 32'h0 with weights_valid = 0 after reset.
  - After the full frame: all 12 entries = 32'h40000000.

Source files
------------

// File: rtl/weight_axis_if.sv
// Weight stream bundle: 32-bit beats with frame delimiter and valid/ready.
// The master drives data and valid; the slave answers with ready.
interface weight_axis_if;
   logic [31:0] tdata;
   logic        tlast;
   logic        tvalid;
   logic        tready;

   modport master (
      output tdata,
      output tlast,
      output tvalid,
      input  tready
   );

   modport slave (
      input  tdata,
      input  tlast,
      input  tvalid,
      output tready
   );
endinterface

// File: rtl/weight_loader.sv
// Streams a ROWS x COLS fp32 weight frame into a shadow matrix and
// swaps it into the active matrix in one cycle once hold is released.
module weight_loader #(
   parameter int ROWS = 3,
   parameter int COLS = 4
) (
   input  logic                               clk,
   input  logic                               rst,
   weight_axis_if.slave                       axis,
   input  logic                               hold,
   output logic [0:ROWS-1][0:COLS-1][31:0]    weights,
   output logic                               weights_valid,
   output logic                               load_error
);

   localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

   typedef enum logic [1:0] {
      ST_LOAD,
      ST_DRAIN,
      ST_COMMIT
   } state_t;

   state_t state, state_n;

   logic [RW-1:0] r, r_n;
   logic [CW-1:0] c, c_n;

   logic [0:ROWS-1][0:COLS-1][31:0] shadow;

   logic beat;
   logic last_k;
   logic wr_en;
   logic commit;
   logic err_set;

   assign beat   = axis.tvalid && axis.tready;
   assign last_k = (r == RW'(ROWS - 1)) && (c == CW'(COLS - 1));

   always_comb begin
      state_n = state;
      r_n     = r;
      c_n     = c;
      wr_en   = 1'b0;
      commit  = 1'b0;
      err_set = 1'b0;
      unique case (state)
         ST_LOAD: begin
            if (beat) begin
               wr_en = 1'b1;
               if (last_k) begin
                  r_n = '0;
                  c_n = '0;
                  if (axis.tlast) begin
                     state_n = ST_COMMIT;
                  end else begin
                     state_n = ST_DRAIN;
                     err_set = 1'b1;
                  end
               end else if (axis.tlast) begin
                  // Short frame: restart, active matrix untouched
                  r_n     = '0;
                  c_n     = '0;
                  err_set = 1'b1;
               end else if (c == CW'(COLS - 1)) begin
                  c_n = '0;
                  r_n = r + 1'b1;
               end else begin
                  c_n = c + 1'b1;
               end
            end
         end
         ST_DRAIN: begin
            if (beat && axis.tlast) begin
               state_n = ST_LOAD;
               r_n     = '0;
               c_n     = '0;
            end
         end
         ST_COMMIT: begin
            if (!hold) begin
               commit  = 1'b1;
               state_n = ST_LOAD;
               r_n     = '0;
               c_n     = '0;
            end
         end
         default: begin
            state_n = ST_LOAD;
            r_n     = '0;
            c_n     = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= ST_LOAD;
         r             <= '0;
         c             <= '0;
         shadow        <= '0;
         weights       <= '0;
         weights_valid <= 1'b0;
         load_error    <= 1'b0;
         axis.tready   <= 1'b0;
      end else begin
         state <= state_n;
         r     <= r_n;
         c     <= c_n;
         if (wr_en) begin
            shadow[r][c] <= axis.tdata;
         end
         if (commit) begin
            weights       <= shadow;
            weights_valid <= 1'b1;
         end
         if (err_set) begin
            load_error <= 1'b1;
         end else if (commit) begin
            load_error <= 1'b0;
         end
         // Ready follows the upcoming state, so it never sees tvalid
         axis.tready <= (state_n != ST_COMMIT);
      end
   end

endmodule

// File: tb/tb_weight_loader.sv
// Directed bench for weight_loader: cycle vector table for full and
// held frames, then hand sequences for short/long/bubble/reset cases.
module tb_weight_loader;

   localparam int ROWS = 3;
   localparam int COLS = 4;

   logic clk  = 1'b0;
   logic rst  = 1'b1;
   logic hold = 1'b0;

   logic [0:ROWS-1][0:COLS-1][31:0] weights;
   logic weights_valid;
   logic load_error;

   weight_axis_if ax ();

   always #5 clk = ~clk;

   weight_loader #(
      .ROWS(ROWS),
      .COLS(COLS)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .axis         (ax),
      .hold         (hold),
      .weights      (weights),
      .weights_valid(weights_valid),
      .load_error   (load_error)
   );

   typedef struct {
      logic        rst;
      logic        tvalid;
      logic        tlast;
      logic        hold;
      logic [31:0] tdata;
      logic        e_tready;
      logic        e_wv;
      logic        e_err;
      logic [31:0] e_w12;
      logic [31:0] e_w23;
   } vec_t;

   vec_t tbl[$];

   int total  = 0;
   int passed = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h want %h", nm, act, exp);
   endtask

   task automatic add(input logic r, input logic tv, input logic tl,
                      input logic hd, input logic [31:0] d,
                      input logic etr, input logic ewv, input logic eerr,
                      input logic [31:0] ew12, input logic [31:0] ew23);
      vec_t v;
      v.rst = r; v.tvalid = tv; v.tlast = tl; v.hold = hd; v.tdata = d;
      v.e_tready = etr; v.e_wv = ewv; v.e_err = eerr;
      v.e_w12 = ew12; v.e_w23 = ew23;
      tbl.push_back(v);
   endtask

   task automatic idle();
      ax.tvalid = 1'b0;
      ax.tlast  = 1'b0;
      hold      = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic [31:0] d, input logic l);
      int n;
      n = 0;
      ax.tvalid = 1'b1;
      ax.tdata  = d;
      ax.tlast  = l;
      while (!ax.tready && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (!ax.tready) begin
         total++;
         $display("FAIL beat_timeout: tready stuck at 0 want 1");
      end
      @(posedge clk);
      #1;
      ax.tvalid = 1'b0;
      ax.tlast  = 1'b0;
   endtask

   task automatic frame(input logic [31:0] base, input logic inc);
      for (int k = 0; k < ROWS * COLS; k++)
         beat(inc ? base + 32'(k) : base, k == ROWS * COLS - 1);
   endtask

   initial begin
      ax.tvalid = 1'b0;
      ax.tlast  = 1'b0;
      ax.tdata  = '0;

      // Reset, then full frame with hold low
      add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      add(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
      for (int k = 0; k < 12; k++)
         add(0, 1, k == 11, 0, 32'h3F800000 + 32'(k),
             k != 11, 0, 0, 0, 0);
      add(0, 0, 0, 0, 0, 1, 1, 0, 32'h3F800006, 32'h3F80000B);
      // Second frame held for 5 cycles after its last beat
      for (int k = 0; k < 12; k++)
         add(0, 1, k == 11, 0, 32'h40000000 + 32'(k),
             k != 11, 1, 0, 32'h3F800006, 32'h3F80000B);
      for (int i = 0; i < 5; i++)
         add(0, 0, 0, 1, 0, 0, 1, 0, 32'h3F800006, 32'h3F80000B);
      add(0, 0, 0, 0, 0, 1, 1, 0, 32'h40000006, 32'h4000000B);

      foreach (tbl[i]) begin
         rst       = tbl[i].rst;
         ax.tvalid = tbl[i].tvalid;
         ax.tlast  = tbl[i].tlast;
         ax.tdata  = tbl[i].tdata;
         hold      = tbl[i].hold;
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_tready", i), 32'(ax.tready),
             32'(tbl[i].e_tready));
         chk($sformatf("v%0d_wvalid", i), 32'(weights_valid),
             32'(tbl[i].e_wv));
         chk($sformatf("v%0d_err", i), 32'(load_error),
             32'(tbl[i].e_err));
         chk($sformatf("v%0d_w12", i), weights[1][2], tbl[i].e_w12);
         chk($sformatf("v%0d_w23", i), weights[2][3], tbl[i].e_w23);
      end
      idle();

      // Short frame: 7 beats then a good frame
      for (int k = 0; k < 7; k++) beat(32'h11110000 + 32'(k), k == 6);
      chk("short_err", 32'(load_error), 32'h1);
      chk("short_w12", weights[1][2], 32'h40000006);
      chk("short_wv", 32'(weights_valid), 32'h1);
      chk("short_tready", 32'(ax.tready), 32'h1);
      frame(32'h3F800000, 1'b1);
      chk("short_pend_err", 32'(load_error), 32'h1);
      chk("short_pend_tready", 32'(ax.tready), 32'h0);
      idle();
      chk("short_ok_err", 32'(load_error), 32'h0);
      chk("short_ok_w00", weights[0][0], 32'h3F800000);
      chk("short_ok_w12", weights[1][2], 32'h3F800006);
      chk("short_ok_w23", weights[2][3], 32'h3F80000B);

      // Long frame: 15 beats, drain after the 12th
      for (int i = 0; i < 15; i++) begin
         beat(32'h55550000 + 32'(i), i == 14);
         if (i == 11) begin
            chk("long_drain_tready", 32'(ax.tready), 32'h1);
            chk("long_drain_err", 32'(load_error), 32'h1);
         end
      end
      idle();
      chk("long_err", 32'(load_error), 32'h1);
      chk("long_w12", weights[1][2], 32'h3F800006);
      chk("long_wv", 32'(weights_valid), 32'h1);
      chk("long_tready", 32'(ax.tready), 32'h1);
      frame(32'h3F900000, 1'b1);
      idle();
      chk("long_next_w00", weights[0][0], 32'h3F900000);
      chk("long_next_w12", weights[1][2], 32'h3F900006);
      chk("long_next_err", 32'(load_error), 32'h0);

      // Bubbles: valid toggles, garbage on idle data
      for (int k = 0; k < 12; k++) begin
         beat(32'h3F800000 + 32'(k), k == 11);
         if (k < 11) begin
            ax.tdata = 32'hDEADBEEF;
            @(posedge clk);
            #1;
         end
      end
      idle();
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++)
            chk($sformatf("bub_w%0d%0d", r, c), weights[r][c],
                32'h3F800000 + 32'(r * COLS + c));

      // Reset in the middle of a frame
      for (int k = 0; k < 5; k++) beat(32'h77770000 + 32'(k), 1'b0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("rst_wv", 32'(weights_valid), 32'h0);
      chk("rst_err", 32'(load_error), 32'h0);
      chk("rst_tready", 32'(ax.tready), 32'h0);
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++)
            chk($sformatf("rst_w%0d%0d", r, c), weights[r][c], 32'h0);
      frame(32'h40000000, 1'b0);
      idle();
      chk("rst_after_wv", 32'(weights_valid), 32'h1);
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++)
            chk($sformatf("rst_after_w%0d%0d", r, c), weights[r][c],
                32'h40000000);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
